// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and width.
package serial_adder_pkg;

  localparam int unsigned SA_STATE_W = 2;

  typedef enum logic [SA_STATE_W-1:0] {
    SA_IDLE = 2'b00,
    SA_RUN  = 2'b01,
    SA_DONE = 2'b10
  } sa_state_e;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle of the bit-serial adder.
interface serial_adder_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/bhalfadd.sv
// Half-adder cell of the downstream datapath.
module bhalfadd (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/fa_cell.sv
// Full adder built from two half-adder cells; carries from both stages are ORed.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic s1_s;
  logic c1_s;
  logic c2_s;

  bhalfadd u_ha0 (.a(a),    .b(b),   .s(s1_s), .c(c1_s));
  bhalfadd u_ha1 (.a(s1_s), .b(cin), .s(s),    .c(c2_s));

  assign co = c1_s | c2_s;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, LSB first, one bit per clock, with valid/ready on
// both the operand and the result side.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sa_state_e        state_r;
  sa_state_e        state_nx_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic [CW-1:0]    cnt_r;
  logic             s_s;
  logic             co_s;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             busy_s;

  fa_cell u_fa (
    .a  (a_sh_r[0]),
    .b  (b_sh_r[0]),
    .cin(carry_r),
    .s  (s_s),
    .co (co_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= SA_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state decode; the unused encoding falls back to IDLE
  always_comb begin
    state_nx_s = SA_IDLE;
    case (state_r)
      SA_IDLE: begin
        if (bus.in_valid) state_nx_s = SA_RUN;
        else              state_nx_s = SA_IDLE;
      end
      SA_RUN: begin
        if (cnt_r == LAST_BIT) state_nx_s = SA_DONE;
        else                   state_nx_s = SA_RUN;
      end
      SA_DONE: begin
        if (bus.out_ready) state_nx_s = SA_IDLE;
        else               state_nx_s = SA_DONE;
      end
      default: state_nx_s = SA_IDLE;
    endcase
  end

  // Handshake/status outputs decoded from the registered state only
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    case (state_r)
      SA_IDLE: in_ready_s  = 1'b1;
      SA_RUN:  busy_s      = 1'b1;
      SA_DONE: out_valid_s = 1'b1;
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
      end
    endcase
  end

  // Operand shifters, carry, bit counter and result; sum/cout move only in RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        SA_IDLE: begin
          if (bus.in_valid) begin
            a_sh_r  <= bus.a;
            b_sh_r  <= bus.b;
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
          end
        end
        SA_RUN: begin
          sum_r   <= {s_s, sum_r[WIDTH-1:1]};
          carry_r <= co_s;
          a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          if (cnt_r == LAST_BIT) begin
            cout_r <= co_s;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          sum_r  <= sum_r;
          cout_r <= cout_r;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.busy      = busy_s;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: per-scenario tasks with a queue of
// expected {cout,sum} values pushed on accept and popped on result handshake.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [W:0] exp_q[$];

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands until accepted; pushes the expected result on accept.
  task automatic drive_op(input logic [W-1:0] opa, input logic [W-1:0] opb);
    logic rdy;
    bus.a = opa;
    bus.b = opb;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      rdy = bus.in_ready;
      tick();
      if (rdy) begin
        exp_q.push_back({1'b0, opa} + {1'b0, opb});
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL accept_timeout: in_ready never seen, required accept within 50 cycles");
  endtask

  task automatic wait_done(output logic ok, output int n);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    ok = bus.out_valid;
  endtask

  function automatic logic [W:0] pop_exp();
    if (exp_q.size() == 0) return {(W+1){1'b1}};
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #3;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b cout=%b sum=%h, required 1 0 0 0 00",
               bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.sum);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b busy=%b, required 1 0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_basic();
    logic ok;
    int   n;
    logic [W:0] e;
    bus.out_ready = 1'b1;
    drive_op(8'h35, 8'h4A);
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_run_flags: busy=%b in_ready=%b, required 1 0", bus.busy, bus.in_ready);
    end
    wait_done(ok, n);
    checks++;
    if (!ok || n !== W) begin
      errors++;
      $display("FAIL basic_latency: out_valid after %0d cycles (seen=%b), required %0d", n, ok, W);
    end
    e = pop_exp();
    checks++;
    if ({bus.cout, bus.sum} !== e || e !== 9'h07F) begin
      errors++;
      $display("FAIL basic_sum: got %h, required %h", {bus.cout, bus.sum}, e);
    end
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum !== 8'h7F) begin
      errors++;
      $display("FAIL basic_back_idle: in_ready=%b out_valid=%b sum=%h, required 1 0 7f",
               bus.in_ready, bus.out_valid, bus.sum);
    end
  endtask

  task automatic test_corners();
    logic [W-1:0] ta[3];
    logic [W-1:0] tb_[3];
    logic ok;
    int   n;
    logic [W:0] e;
    ta[0] = 8'hFF; tb_[0] = 8'h01;
    ta[1] = 8'hFF; tb_[1] = 8'hFF;
    ta[2] = 8'h00; tb_[2] = 8'h00;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_op(ta[i], tb_[i]);
      wait_done(ok, n);
      e = pop_exp();
      checks++;
      if (!ok || {bus.cout, bus.sum} !== e) begin
        errors++;
        $display("FAIL corner_%0d: %h+%h got %h (valid=%b), required %h",
                 i, ta[i], tb_[i], {bus.cout, bus.sum}, ok, e);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    int   n;
    logic [W:0] e;
    bus.out_ready = 1'b0;
    drive_op(8'h80, 8'h80);
    wait_done(ok, n);
    e = pop_exp();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (!ok || bus.out_valid !== 1'b1 || {bus.cout, bus.sum} !== e) begin
        errors++;
        $display("FAIL backpressure_hold_%0d: valid=%b result=%h, required 1 %h",
                 i, bus.out_valid, {bus.cout, bus.sum}, e);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || {bus.cout, bus.sum} !== 9'h100) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b result=%h, required 0 1 100",
               bus.out_valid, bus.in_ready, {bus.cout, bus.sum});
    end
  endtask

  task automatic test_in_valid_during_run();
    logic ok;
    int   n;
    logic [W:0] e;
    bus.out_ready = 1'b1;
    drive_op(8'h0F, 8'h01);
    bus.a = 8'h11;
    bus.b = 8'h22;
    bus.in_valid = 1'b1;
    wait_done(ok, n);
    e = pop_exp();
    checks++;
    if (!ok || {bus.cout, bus.sum} !== e || exp_q.size() != 0) begin
      errors++;
      $display("FAIL run_ignore_in_valid: got %h (valid=%b, queued=%0d), required %h",
               {bus.cout, bus.sum}, ok, exp_q.size(), e);
    end
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum !== 8'h10) begin
      errors++;
      $display("FAIL done_to_idle_only: in_ready=%b out_valid=%b sum=%h, required 1 0 10",
               bus.in_ready, bus.out_valid, bus.sum);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL second_accept: busy=%b, required 1", bus.busy);
    end
    exp_q.push_back(9'h033);
    wait_done(ok, n);
    e = pop_exp();
    checks++;
    if (!ok || {bus.cout, bus.sum} !== e) begin
      errors++;
      $display("FAIL second_result: got %h (valid=%b), required %h", {bus.cout, bus.sum}, ok, e);
    end
    tick();
  endtask

  task automatic test_async_reset();
    logic ok;
    int   n;
    logic [W:0] e;
    bus.out_ready = 1'b1;
    drive_op(8'hFF, 8'hFF);
    repeat (3) @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL async_reset: in_ready=%b out_valid=%b busy=%b cout=%b sum=%h, required 1 0 0 0 00",
               bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.sum);
    end
    exp_q.delete();
    #2;
    rst = 1'b0;
    tick();
    drive_op(8'h01, 8'h02);
    wait_done(ok, n);
    e = pop_exp();
    checks++;
    if (!ok || {bus.cout, bus.sum} !== e || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_add: got %h (valid=%b), required %h", {bus.cout, bus.sum}, ok, e);
    end
    tick();
  endtask

  task automatic test_random();
    localparam int N = 1000;
    int sent = 0;
    int got = 0;
    logic p_iv, p_ir, p_ov, p_or, p_cout;
    logic [W-1:0] p_sum, p_a, p_b;
    logic [W:0] e;
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc < 40000 && (sent < N || got < N); cyc++) begin
      if (!bus.in_valid && sent < N && $urandom_range(0, 2) != 0) begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.in_valid = 1'b1;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      p_iv = bus.in_valid;  p_ir = bus.in_ready;
      p_ov = bus.out_valid; p_or = bus.out_ready;
      p_sum = bus.sum;      p_cout = bus.cout;
      p_a = bus.a;          p_b = bus.b;
      tick();
      if (p_iv && p_ir) begin
        exp_q.push_back({1'b0, p_a} + {1'b0, p_b});
        sent++;
        bus.in_valid = 1'b0;
      end
      if (p_ov && p_or) begin
        got++;
        e = pop_exp();
        checks++;
        if ({p_cout, p_sum} !== e) begin
          errors++;
          $display("FAIL random_result_%0d: got %h, required %h", got, {p_cout, p_sum}, e);
        end
      end else if (p_ov) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.sum !== p_sum || bus.cout !== p_cout) begin
          errors++;
          $display("FAIL random_stall_stable: valid=%b result=%h, required 1 %h",
                   bus.out_valid, {bus.cout, bus.sum}, {p_cout, p_sum});
        end
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (got != N) begin
      errors++;
      $display("FAIL random_count: completed %0d transactions, required %0d", got, N);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_in_valid_during_run();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder of two WIDTH-bit unsigned operands, LSB first, one bit per clock.
- Per-bit sum/carry comes from a full-adder cell built from two bhalfadd instances plus an OR gate.
- Sits directly upstream of the half-adder datapath: it sequences operand bits into the half-adder cells and collects their sum/carry outputs into a parallel result.
- Valid/ready handshake on both sides.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal values are 2 and above.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operands a/b are presented
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  WIDTH  operand A, sampled on accept
- b  input  WIDTH  operand B, sampled on accept
- out_valid  output  1  result available; high only in DONE
- out_ready  input  1  consumer takes the result
- sum  output  WIDTH  (a+b) mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- busy  output  1  high in RUN

Behaviour:
- Reset: one clock, clk. rst is asynchronous and active-high. While rst is high the block is forced, independent of clk, to:
  - state IDLE
  - in_ready=1, out_valid=0, busy=0
  - sum=0, cout=0
  - internal carry=0, bit counter=0, operand shift registers=0
- State encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10. 2'b11 is unreachable and decodes to IDLE on the next edge.
- IDLE:
  - in_ready=1.
  - Accept occurs on an edge where in_valid=1 while in IDLE.
  - On accept: latch a and b into shift registers, clear carry and counter, go to RUN.
  - On accept, sum and cout keep their previous values; they change only during RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each edge: s = a_sh[0]^b_sh[0]^carry, and carry <= majority(a_sh[0], b_sh[0], carry).
  - s shifts into sum MSB-side, i.e. sum <= {s, sum[WIDTH-1:1]}.
  - a_sh and b_sh shift right by 1; counter increments.
  - On the edge where counter == WIDTH-1, the final bit is processed, cout <= new carry, and the state goes to DONE.
  - Counter width is $clog2(WIDTH). It never wraps past WIDTH-1.
- Latency: accept at edge E0 gives out_valid=1 from edge E0+WIDTH, i.e. WIDTH cycles.
- DONE:
  - out_valid=1, busy=0, in_ready=0.
  - sum and cout are held stable for as long as out_ready=0.
  - On an edge with out_ready=1, go to IDLE; out_valid drops and sum/cout keep their values.
- Throughput: one result per WIDTH+2 cycles at full rate (accept edge, WIDTH RUN edges, DONE→IDLE edge). There is no overlap of accept and DONE.
- Boundary conditions:
  - in_valid in RUN or DONE: ignored; a/b are not sampled.
  - out_ready in IDLE or RUN: no effect.
  - in_valid and out_ready both high in DONE: only the DONE→IDLE transition occurs; the new operands are accepted on the following edge if in_valid is still high.
  - rst asserted mid-RUN or in DONE: immediate return to reset values; the partial result is discarded.
  - Carry ripple across all bits, e.g. all-ones + 1: the carry chain is handled purely by the carry register; no special case is needed.
- All outputs are registered or decoded from the registered state only. There is no combinational path from any input to any output.

Decomposition:
- Shared constants file, included by RTL and bench:
  - state encodings SA_IDLE, SA_RUN, SA_DONE
  - state width 2
- Sub-module fa_cell (a, b, cin → s, co):
  - two bhalfadd instances
  - co = c1 | c2
- serial_adder instantiates one fa_cell combinationally. Registers, FSM and shift logic live in serial_adder.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, out_ready=1 → out_valid rises exactly 8 cycles after the accept edge; sum=0x7F, cout=0; back in IDLE one cycle later.
- a=0xFF, b=0x01 → sum=0x00, cout=1. a=0xFF, b=0xFF → sum=0xFE, cout=1. a=0x00, b=0x00 → sum=0x00, cout=0.
- Backpressure: a=0x80, b=0x80, out_ready held 0 for 5 cycles after out_valid → sum=0x00 and cout=1 are stable throughout; single handshake on release; in_ready returns 1 the next cycle.
- in_valid held high with new a/b (0x11, 0x22) throughout RUN of a 0x0F+0x01 add → first result is 0x10, cout=0; 0x11+0x22=0x33 is accepted only after DONE→IDLE.
- Assert rst asynchronously (mid-cycle) after 3 RUN cycles → outputs go to reset values before the next clk edge; a subsequent 0x01+0x02 yields 0x03, cout=0, with no residual carry.
- Random regression, 1000 operand pairs with random in_valid/out_ready gaps → {cout,sum} equals a+b for every transaction; outputs never change while out_valid=1 and out_ready=0.
